// File: rtl/soml_cand_search_ctrl_if.sv
// Column-request stream to the S-ROM/metric datapath and the metric return path.
interface soml_cand_search_ctrl_if #(
   parameter int unsigned METRIC_W = 32
);
   logic [3:0]          rom_si;
   logic [1:0]          rom_col;
   logic                col_valid;
   logic                col_last;
   logic                dp_ready;
   logic [METRIC_W-1:0] metric_in;
   logic                metric_valid;

   modport master (
      output rom_si, rom_col, col_valid, col_last,
      input  dp_ready, metric_in, metric_valid
   );

   modport slave (
      input  rom_si, rom_col, col_valid, col_last,
      output dp_ready, metric_in, metric_valid
   );
endinterface

// File: rtl/soml_cand_search_ctrl.sv
// Candidate-S search controller: walks every (Si, colS) pair into the metric
// datapath and keeps the lowest-metric candidate index (ties keep the lower one).
module soml_cand_search_ctrl #(
   parameter int unsigned METRIC_W = 32,
   parameter int unsigned NUM_CAND = 16,
   parameter int unsigned NUM_COL  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   soml_cand_search_ctrl_if.master dp,
   output logic                    busy,
   output logic                    done,
   output logic [3:0]              best_idx,
   output logic [METRIC_W-1:0]     best_metric,
   output logic                    proto_err
);
   localparam logic [3:0] LAST_SI  = 4'(NUM_CAND - 1);
   localparam logic [1:0] LAST_COL = 2'(NUM_COL - 1);
   localparam logic [4:0] RCV_FULL = 5'(NUM_CAND);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t              state_q;
   logic [3:0]          si_q;
   logic [1:0]          col_q;
   logic [4:0]          rcv_q, rcv_d;
   logic [METRIC_W-1:0] min_q, min_d;
   logic [3:0]          min_idx_q, min_idx_d;
   logic [3:0]          best_idx_q;
   logic [METRIC_W-1:0] best_metric_q;
   logic                proto_err_q;
   logic                collecting, accept, last_beat, overflow, all_rcv;

   always_comb begin
      collecting = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      accept     = (state_q == S_ISSUE) && dp.dp_ready;
      last_beat  = accept && (si_q == LAST_SI) && (col_q == LAST_COL);
      overflow   = dp.metric_valid && (rcv_q == RCV_FULL);
      rcv_d      = rcv_q;
      min_d      = min_q;
      min_idx_d  = min_idx_q;
      // Strict less-than: an equal later metric never displaces the earlier index.
      if (collecting && dp.metric_valid && !overflow) begin
         rcv_d = rcv_q + 5'd1;
         if (dp.metric_in < min_q) begin
            min_d     = dp.metric_in;
            min_idx_d = rcv_q[3:0];
         end
      end
      all_rcv = (rcv_d == RCV_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         si_q          <= '0;
         col_q         <= '0;
         rcv_q         <= '0;
         min_q         <= '1;
         min_idx_q     <= '0;
         best_idx_q    <= '0;
         best_metric_q <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (dp.metric_valid) proto_err_q <= 1'b1;
               if (start) begin
                  state_q     <= S_ISSUE;
                  si_q        <= '0;
                  col_q       <= '0;
                  rcv_q       <= '0;
                  min_q       <= '1;
                  min_idx_q   <= '0;
                  proto_err_q <= 1'b0;
               end
            end
            S_ISSUE, S_DRAIN: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  si_q    <= '0;
                  col_q   <= '0;
               end else begin
                  rcv_q     <= rcv_d;
                  min_q     <= min_d;
                  min_idx_q <= min_idx_d;
                  if (overflow) proto_err_q <= 1'b1;
                  if (accept) begin
                     if (col_q == LAST_COL) begin
                        col_q <= '0;
                        si_q  <= si_q + 4'd1;
                     end else begin
                        col_q <= col_q + 2'd1;
                     end
                  end
                  // A full set of metrics only completes once every beat has issued.
                  if ((state_q == S_DRAIN || last_beat) && all_rcv) begin
                     state_q       <= S_DONE;
                     best_idx_q    <= min_idx_d;
                     best_metric_q <= min_d;
                  end else if (last_beat) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DONE: begin
               if (dp.metric_valid) proto_err_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dp.rom_si    = si_q;
   assign dp.rom_col   = col_q;
   assign dp.col_valid = (state_q == S_ISSUE);
   assign dp.col_last  = (state_q == S_ISSUE) && (col_q == LAST_COL);
   assign busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done         = (state_q == S_DONE);
   assign best_idx     = best_idx_q;
   assign best_metric  = best_metric_q;
   assign proto_err    = proto_err_q;
endmodule

// File: tb/tb_soml_cand_search_ctrl.sv
// Bench for soml_cand_search_ctrl: table of searches plus randomized searches
// against an argmin reference model, with abort/reset/protocol corner sequences.
module tb_soml_cand_search_ctrl;
   localparam int unsigned MW = 32;

   logic          clk;
   logic          rst, start, abort;
   logic          busy, done, proto_err;
   logic [3:0]    best_idx;
   logic [MW-1:0] best_metric;

   soml_cand_search_ctrl_if #(.METRIC_W(MW)) dp_if ();

   soml_cand_search_ctrl #(.METRIC_W(MW), .NUM_CAND(16), .NUM_COL(2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .dp(dp_if),
      .busy(busy), .done(done), .best_idx(best_idx), .best_metric(best_metric),
      .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   logic [MW-1:0] met [16];

   typedef struct {
      int              ready_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
      int              abort_at;     // beats accepted before abort, -1 none
      int              pat;          // 0: 100-si with si9=5, 1: 7 at si3/si11 else 50
      bit              exp_done;
      int              exp_idx;
      longint unsigned exp_met;
      bit              inj_done_metric;
   } vec_t;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_pat(input int pat);
      for (int i = 0; i < 16; i++) begin
         if (pat == 0) met[i] = (i == 9) ? 32'd5 : 32'(100 - i);
         else          met[i] = (i == 3 || i == 11) ? 32'd7 : 32'd50;
      end
   endtask

   // Reference: first index holding the smallest value.
   task automatic model_best(output int idx, output longint unsigned m);
      idx = 0;
      m   = met[0];
      for (int i = 1; i < 16; i++)
         if (met[i] < m) begin
            m   = met[i];
            idx = i;
         end
   endtask

   task automatic run_search(input int ready_mode, input int abort_at, input bit rst_drain,
                             input bit exp_done, input int e_idx, input longint unsigned e_met);
      int            due_q[$];
      logic [MW-1:0] val_q[$];
      int            k, last_cyc, lat, last_due;
      bit            fin, stalled, r, ab, rs;
      logic [3:0]    psi;
      logic [1:0]    pcol;
      bit            rpat [4];
      rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1;
      lat      = (ready_mode == 2) ? int'($urandom_range(1, 5)) : 3;
      k        = 0;
      last_cyc = -1;
      last_due = 0;
      fin      = 1'b0;
      stalled  = 1'b0;
      psi      = '0;
      pcol     = '0;

      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_clears_proto", proto_err, 0);

      for (int cyc = 1; cyc < 400 && !fin; cyc++) begin
         if (done) begin
            fin = 1'b1;
            chk("done_expected", done, exp_done);
            chk("done_after_all_beats", k, 32);
            chk("best_idx", best_idx, e_idx);
            chk("best_metric", best_metric, e_met);
            chk("metrics_all_returned", due_q.size(), 0);
            if (ready_mode == 0) chk("last_beat_cycle", last_cyc, 32);
         end else begin
            chk("busy", busy, 1);
            chk("col_valid", dp_if.col_valid, (k < 32) ? 1 : 0);
            if (stalled) begin
               chk("stall_si", dp_if.rom_si, psi);
               chk("stall_col", dp_if.rom_col, pcol);
            end
            case (ready_mode)
               0:       r = 1'b1;
               1:       r = rpat[cyc % 4];
               default: r = 1'($urandom % 2);
            endcase
            ab = (abort_at >= 0) && (k == abort_at);
            rs = rst_drain && (k == 32);
            stalled = 1'b0;
            if (dp_if.col_valid && !ab && !rs) begin
               if (r) begin
                  chk("beat_si", dp_if.rom_si, k / 2);
                  chk("beat_col", dp_if.rom_col, k % 2);
                  chk("beat_last", dp_if.col_last, k % 2);
                  if (k % 2 == 1) begin
                     last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                     due_q.push_back(last_due);
                     val_q.push_back(met[k / 2]);
                  end
                  if (k == 31) last_cyc = cyc;
                  k++;
               end else begin
                  stalled = 1'b1;
                  psi     = dp_if.rom_si;
                  pcol    = dp_if.rom_col;
               end
            end
            dp_if.metric_valid = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc && !ab && !rs) begin
               void'(due_q.pop_front());
               dp_if.metric_in    = val_q.pop_front();
               dp_if.metric_valid = 1'b1;
            end
            dp_if.dp_ready = r;
            abort = ab;
            rst   = rs;
            step();
            abort = 1'b0;
            rst   = 1'b0;
            dp_if.metric_valid = 1'b0;
            dp_if.dp_ready     = 1'b0;
            if (ab) begin
               fin = 1'b1;
               chk("abort_col_valid", dp_if.col_valid, 0);
               chk("abort_busy", busy, 0);
               chk("abort_no_done", done, 0);
               chk("abort_best_idx", best_idx, e_idx);
               chk("abort_best_metric", best_metric, e_met);
            end
            if (rs) begin
               fin = 1'b1;
               chk("rst_busy", busy, 0);
               chk("rst_done", done, 0);
               chk("rst_proto", proto_err, 0);
               chk("rst_best_idx", best_idx, 0);
               chk("rst_best_metric", best_metric, 0);
               chk("rst_col_valid", dp_if.col_valid, 0);
               chk("rst_col_last", dp_if.col_last, 0);
               chk("rst_rom_si", dp_if.rom_si, 0);
               chk("rst_rom_col", dp_if.rom_col, 0);
            end
         end
      end
      if (!fin) chk("search_timeout", 0, 1);
   endtask

   vec_t vecs [5];

   initial begin
      int              ridx;
      longint unsigned rmet;

      vecs[0] = '{0, -1, 0, 1'b1, 9, 64'd5, 1'b0};
      vecs[1] = '{1, -1, 0, 1'b1, 9, 64'd5, 1'b0};
      vecs[2] = '{0, -1, 1, 1'b1, 3, 64'd7, 1'b0};
      vecs[3] = '{0, 10, 0, 1'b0, 3, 64'd7, 1'b0};
      vecs[4] = '{2, -1, 0, 1'b1, 9, 64'd5, 1'b1};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      dp_if.dp_ready = 1'b0; dp_if.metric_valid = 1'b0; dp_if.metric_in = '0;
      repeat (3) step();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_proto", proto_err, 0);
      chk("reset_best_idx", best_idx, 0);
      chk("reset_best_metric", best_metric, 0);
      chk("reset_col_valid", dp_if.col_valid, 0);
      chk("reset_col_last", dp_if.col_last, 0);
      chk("reset_rom_si", dp_if.rom_si, 0);
      chk("reset_rom_col", dp_if.rom_col, 0);
      rst = 1'b0;
      step();
      chk("idle_col_valid", dp_if.col_valid, 0);

      foreach (vecs[i]) begin
         fill_pat(vecs[i].pat);
         run_search(vecs[i].ready_mode, vecs[i].abort_at, 1'b0, vecs[i].exp_done,
                    vecs[i].exp_idx, vecs[i].exp_met);
         if (vecs[i].exp_done) begin
            // A metric arriving in the DONE cycle is a protocol error and is dropped.
            dp_if.metric_valid = vecs[i].inj_done_metric;
            dp_if.metric_in    = '0;
            step();
            dp_if.metric_valid = 1'b0;
            chk("post_done_low", done, 0);
            chk("post_done_busy", busy, 0);
            chk("post_done_proto", proto_err, vecs[i].inj_done_metric);
            chk("post_done_best_idx", best_idx, vecs[i].exp_idx);
            chk("post_done_best_metric", best_metric, vecs[i].exp_met);
         end
      end

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) begin
            if (r == 0 || $urandom_range(0, 7) == 0) met[i] = '1;
            else                                     met[i] = MW'($urandom_range(0, 15));
         end
         model_best(ridx, rmet);
         run_search(2, -1, 1'b0, 1'b1, ridx, rmet);
         step();
         chk("rand_done_low", done, 0);
      end

      dp_if.metric_valid = 1'b1;
      dp_if.metric_in    = '0;
      step();
      dp_if.metric_valid = 1'b0;
      chk("idle_metric_proto", proto_err, 1);
      chk("idle_metric_best_idx", best_idx, ridx);
      chk("idle_metric_best_metric", best_metric, rmet);
      step();
      chk("idle_metric_proto_sticky", proto_err, 1);

      fill_pat(1);
      run_search(0, -1, 1'b1, 1'b0, 0, 0);
      step();
      chk("after_rst_idle_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
